tdm_demux8: RTL

//   Receive-side 1:8 time-division demultiplexer, the inverse of the 8:1 channel mux.

---
 rtl/tdm_demux8.sv | 89 ++++++++
 1 files changed

// File: rtl/tdm_demux8.sv
// Receive-side 1:8 TDM demultiplexer: aligns to frame_sync on channel 0, gathers
// eight samples in a shadow buffer and publishes them as one parallel frame.
//
// state | meaning
// HUNT  | waiting for a valid beat with frame_sync to start a frame
// LOCK  | aligned; cnt tracks the slot of the next valid beat
module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [8*W-1:0] dout,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked,
  output logic [2:0]     chan_idx
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]     state;
  logic [2:0]     cnt;
  logic [W-1:0]   shadow [7];
  logic [8*W-1:0] frame_next;

  // The channel-7 beat goes straight to dout without a shadow slot.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < 7; k++) begin
      frame_next[k*W +: W] = shadow[k];
    end
    frame_next[7*W +: W] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= 3'd0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow[0] <= din;
              cnt       <= 3'd1;
              state     <= LOCK;
            end
          end
          default: begin
            if (frame_sync) begin
              // Sync mid-frame restarts the frame from this beat.
              shadow[0] <= din;
              cnt       <= 3'd1;
              if (cnt != 3'd0) begin
                sync_err <= 1'b1;
              end
            end else if (cnt == 3'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else if (cnt == 3'd7) begin
              dout        <= frame_next;
              frame_valid <= 1'b1;
              cnt         <= 3'd0;
            end else begin
              shadow[cnt] <= din;
              cnt         <= cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign locked   = (state == LOCK);
  assign chan_idx = cnt;

endmodule
